alu_share_arb: RTL and testbench

- Shares one combinational ALU between two requesters, port 0 and port 1, for example a main issue path and an address/branch helper path.
- Arbitrates round-robin, or with fixed priority when configured.
- Registers the granted operands into a single issue stage that drives the ALU.
- Captures each ALU result into a per-requester response register, held until that requester accepts it.

---
 rtl/alu_share_arb.sv | 174 +++++++++++++++++
 tb/tb_alu_share_arb.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arb.sv
// Two-port arbiter that shares one combinational ALU.
// One registered issue stage drives the ALU. Each port has a response
// register that is held until that port accepts it.

// Per-port response register. A completion loads new data and raises valid.
// A handshake with no completion in the same cycle clears valid.
module alu_share_rsp #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cpl_valid,
  input  logic [XLEN-1:0] cpl_result,
  input  logic            cpl_zero,
  input  logic            rsp_ready,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_result,
  output logic            rsp_zero
);

  // completion has priority over drain, so a same-cycle pair never loses data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
    end else if (cpl_valid) begin
      rsp_valid  <= 1'b1;
      rsp_result <= cpl_result;
      rsp_zero   <= cpl_zero;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

endmodule

module alu_share_arb #(
  parameter int XLEN       = 32,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  // port 0
  input  logic            r0_req_valid,
  output logic            r0_req_ready,
  input  logic [XLEN-1:0] r0_a,
  input  logic [XLEN-1:0] r0_b,
  input  logic [3:0]      r0_ctrl,
  output logic            r0_rsp_valid,
  input  logic            r0_rsp_ready,
  output logic [XLEN-1:0] r0_rsp_result,
  output logic            r0_rsp_zero,
  // port 1
  input  logic            r1_req_valid,
  output logic            r1_req_ready,
  input  logic [XLEN-1:0] r1_a,
  input  logic [XLEN-1:0] r1_b,
  input  logic [3:0]      r1_ctrl,
  output logic            r1_rsp_valid,
  input  logic            r1_rsp_ready,
  output logic [XLEN-1:0] r1_rsp_result,
  output logic            r1_rsp_zero,
  // shared ALU
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero
);

  localparam int NP = 2;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [3:0]      ctrl;
  } op_t;

  op_t                      req_op [NP];
  logic [NP-1:0]            req_valid;
  logic [NP-1:0]            rsp_ready;
  logic [NP-1:0]            rsp_valid;
  logic [NP-1:0][XLEN-1:0]  rsp_result;
  logic [NP-1:0]            rsp_zero;
  logic [NP-1:0]            busy;
  logic [NP-1:0]            elig;
  logic [NP-1:0]            grant;
  logic [NP-1:0]            cpl;

  logic issue_valid;
  logic issue_id;
  op_t  issue_op;
  logic last_grant;

  // flatten the two request ports into indexable arrays
  assign req_op[0] = {r0_a, r0_b, r0_ctrl};
  assign req_op[1] = {r1_a, r1_b, r1_ctrl};
  assign req_valid = {r1_req_valid, r0_req_valid};
  assign rsp_ready = {r1_rsp_ready, r0_rsp_ready};

  genvar n;
  generate
    for (n = 0; n < NP; n++) begin : g_port
      // A port is busy while its op sits in the issue stage, or while its
      // response is still held. A response drained this cycle frees it.
      assign cpl[n]  = issue_valid & (issue_id == 1'(n));
      assign busy[n] = cpl[n] | (rsp_valid[n] & ~rsp_ready[n]);
      assign elig[n] = req_valid[n] & ~busy[n];

      alu_share_rsp #(.XLEN(XLEN)) u_rsp (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpl_valid  (cpl[n]),
        .cpl_result (alu_result),
        .cpl_zero   (alu_zero),
        .rsp_ready  (rsp_ready[n]),
        .rsp_valid  (rsp_valid[n]),
        .rsp_result (rsp_result[n]),
        .rsp_zero   (rsp_zero[n])
      );
    end
  endgenerate

  // Grant is one-hot or none. On a tie, round-robin hands the grant to the
  // port that did not win last. Fixed priority always picks port 0.
  always_comb begin
    grant = '0;
    case (elig)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11: begin
        if (FIXED_PRIO) grant = 2'b01;
        else            grant = last_grant ? 2'b01 : 2'b10;
      end
      default: grant = '0;
    endcase
  end

  // Ready comes only from valid and internal state. It is forced low while
  // reset is asserted.
  assign r0_req_ready = grant[0] & rst_n;
  assign r1_req_ready = grant[1] & rst_n;

  // Issue stage: load the granted op. With no grant, drop valid and keep
  // the operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_valid <= 1'b0;
      issue_id    <= 1'b0;
      issue_op    <= '0;
      last_grant  <= 1'b1;
    end else if (|grant) begin
      issue_valid <= 1'b1;
      issue_id    <= grant[1];
      issue_op    <= grant[1] ? req_op[1] : req_op[0];
      last_grant  <= grant[1];
    end else begin
      issue_valid <= 1'b0;
    end
  end

  assign alu_a    = issue_op.a;
  assign alu_b    = issue_op.b;
  assign alu_ctrl = issue_op.ctrl;

  assign r0_rsp_valid  = rsp_valid[0];
  assign r0_rsp_result = rsp_result[0];
  assign r0_rsp_zero   = rsp_zero[0];
  assign r1_rsp_valid  = rsp_valid[1];
  assign r1_rsp_result = rsp_result[1];
  assign r1_rsp_zero   = rsp_zero[1];

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb. Two instances share the same stimulus:
// index 0 uses round-robin and index 1 uses fixed priority.
module tb_alu_share_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  v, rr;
  logic [31:0] a [2];
  logic [31:0] b [2];
  logic [3:0]  c [2];

  logic [1:0]  q_rdy [2];
  logic [1:0]  q_vld [2];
  logic [1:0]  q_zero [2];
  logic [31:0] q_res [2][2];
  logic [31:0] q_alu_a [2];
  logic [31:0] q_alu_b [2];
  logic [31:0] q_alu_r [2];
  logic [3:0]  q_alu_c [2];
  logic        q_alu_z [2];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // reference ALU: RISC-V style {funct7[5], funct3} codes
  function automatic logic [31:0] alu_f(input logic [31:0] x, input logic [31:0] y,
                                        input logic [3:0] op);
    case (op)
      4'b0000: return x + y;
      4'b1000: return x - y;
      4'b0001: return x << y[4:0];
      4'b0010: return {31'b0, $signed(x) < $signed(y)};
      4'b0011: return {31'b0, x < y};
      4'b0100: return x ^ y;
      4'b0101: return x >> y[4:0];
      4'b1101: return 32'($signed(x) >>> y[4:0]);
      4'b0110: return x | y;
      4'b0111: return x & y;
      default: return 32'h0;
    endcase
  endfunction

  for (genvar d = 0; d < 2; d++) begin : g_dut
    assign q_alu_r[d] = alu_f(q_alu_a[d], q_alu_b[d], q_alu_c[d]);
    assign q_alu_z[d] = (q_alu_r[d] == 32'h0);

    alu_share_arb #(.XLEN(32), .FIXED_PRIO(d == 1)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .r0_req_valid  (v[0]),
      .r0_req_ready  (q_rdy[d][0]),
      .r0_a          (a[0]),
      .r0_b          (b[0]),
      .r0_ctrl       (c[0]),
      .r0_rsp_valid  (q_vld[d][0]),
      .r0_rsp_ready  (rr[0]),
      .r0_rsp_result (q_res[d][0]),
      .r0_rsp_zero   (q_zero[d][0]),
      .r1_req_valid  (v[1]),
      .r1_req_ready  (q_rdy[d][1]),
      .r1_a          (a[1]),
      .r1_b          (b[1]),
      .r1_ctrl       (c[1]),
      .r1_rsp_valid  (q_vld[d][1]),
      .r1_rsp_ready  (rr[1]),
      .r1_rsp_result (q_res[d][1]),
      .r1_rsp_zero   (q_zero[d][1]),
      .alu_a         (q_alu_a[d]),
      .alu_b         (q_alu_b[d]),
      .alu_ctrl      (q_alu_c[d]),
      .alu_result    (q_alu_r[d]),
      .alu_zero      (q_alu_z[d])
    );
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk2(input string nm, input logic [1:0] act, input logic [1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // inputs change 1 time unit after the rising edge; outputs are sampled 4 after
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic set_op(input int p, input logic [31:0] x, input logic [31:0] y,
                        input logic [3:0] op);
    a[p] = x;
    b[p] = y;
    c[p] = op;
  endtask

  // Holds reset for two edges and checks the reset outputs along the way.
  // Returns just after an edge with reset released.
  task automatic do_reset();
    rst_n = 1'b0;
    v = 2'b00;
    rr = 2'b11;
    set_op(0, 0, 0, 0);
    set_op(1, 0, 0, 0);
    tick();
    v = 2'b11;
    settle();
    for (int d = 0; d < 2; d++) begin
      chk2("reset_req_ready", q_rdy[d], 2'b00);
      chk2("reset_rsp_valid", q_vld[d], 2'b00);
      chk("reset_alu_a", q_alu_a[d], 32'h0);
      chk("reset_rsp_result", q_res[d][0], 32'h0);
    end
    tick();
    v = 2'b00;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic [31:0] res;
    logic        zero;
  } vec_t;

  vec_t vecs [11];

  logic [3:0] codes [10];

  // state of the transaction-level model used in the random phase
  bit          m_pend [2][2];
  bit          m_vis  [2][2];
  logic [31:0] m_res  [2][2];
  bit          m_last [2];

  initial begin
    int k;
    logic [1:0] el, eg, bz;

    vecs[0]  = '{32'd5,        32'd3,        4'b0000, 32'd8,        1'b0};
    vecs[1]  = '{32'd7,        32'd7,        4'b1000, 32'd0,        1'b1};
    vecs[2]  = '{32'd1,        32'd4,        4'b0001, 32'd16,       1'b0};
    vecs[3]  = '{32'd0,        32'd1,        4'b1000, 32'hFFFFFFFF, 1'b0};
    vecs[4]  = '{32'hFFFFFFFF, 32'd1,        4'b0000, 32'd0,        1'b1};
    vecs[5]  = '{32'hF0F0F0F0, 32'h0FF00FF0, 4'b0111, 32'h00F000F0, 1'b0};
    vecs[6]  = '{32'h80000000, 32'd4,        4'b1101, 32'hF8000000, 1'b0};
    vecs[7]  = '{32'd2,        32'hFFFFFFFF, 4'b0010, 32'd0,        1'b1};
    vecs[8]  = '{32'd2,        32'hFFFFFFFF, 4'b0011, 32'd1,        1'b0};
    vecs[9]  = '{32'h12345678, 32'h12345678, 4'b0100, 32'd0,        1'b1};
    vecs[10] = '{32'hA5A50000, 32'h00005A5A, 4'b0110, 32'hA5A55A5A, 1'b0};

    codes = '{4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011,
              4'b0100, 4'b0101, 4'b1101, 4'b0110, 4'b0111};

    // ---- table: single ops on port 0 ----
    do_reset();
    for (int i = 0; i < 11; i++) begin
      v = 2'b01;
      set_op(0, vecs[i].a, vecs[i].b, vecs[i].ctrl);
      settle();
      k = 0;
      while (!q_rdy[0][0] && k < 10) begin
        tick();
        settle();
        k++;
      end
      chkb("vec_req_ready", q_rdy[0][0], 1'b1);
      tick();
      v = 2'b00;
      chk("vec_alu_a", q_alu_a[0], vecs[i].a);
      chk("vec_alu_b", q_alu_b[0], vecs[i].b);
      chk("vec_alu_ctrl", {28'h0, q_alu_c[0]}, {28'h0, vecs[i].ctrl});
      chkb("vec_rsp_early", q_vld[0][0], 1'b0);
      tick();
      chkb("vec_rsp_valid", q_vld[0][0], 1'b1);
      chk("vec_rsp_result", q_res[0][0], vecs[i].res);
      chkb("vec_rsp_zero", q_zero[0][0], vecs[i].zero);
      tick();
    end

    // ---- contention from reset, both arbitration modes ----
    do_reset();
    v = 2'b11;
    rr = 2'b11;
    set_op(0, 32'd7, 32'd7, 4'b1000);
    set_op(1, 32'd1, 32'd4, 4'b0001);
    for (int i = 0; i < 8; i++) begin
      settle();
      for (int d = 0; d < 2; d++) begin
        chk2("contend_grant", q_rdy[d], (i % 2 == 0) ? 2'b01 : 2'b10);
        if (i == 2) begin
          chkb("contend_r0_valid", q_vld[d][0], 1'b1);
          chk("contend_r0_result", q_res[d][0], 32'd0);
          chkb("contend_r0_zero", q_zero[d][0], 1'b1);
        end
        if (i == 3) begin
          chkb("contend_r1_valid", q_vld[d][1], 1'b1);
          chk("contend_r1_result", q_res[d][1], 32'd16);
          chkb("contend_r1_zero", q_zero[d][1], 1'b0);
        end
      end
      tick();
    end

    // ---- backpressure on port 1 ----
    do_reset();
    rr = 2'b01;
    v = 2'b10;
    set_op(1, 32'd0, 32'd1, 4'b1000);
    settle();
    chkb("bp_r1_first_ready", q_rdy[0][1], 1'b1);
    tick();
    set_op(1, 32'd3, 32'd4, 4'b0000);
    settle();
    chkb("bp_r1_busy_issue", q_rdy[0][1], 1'b0);
    tick();
    v = 2'b11;
    set_op(0, 32'd100, 32'd1, 4'b0000);
    settle();
    chkb("bp_r1_rsp_valid", q_vld[0][1], 1'b1);
    chk("bp_r1_rsp_result", q_res[0][1], 32'hFFFFFFFF);
    chkb("bp_r1_ready_held", q_rdy[0][1], 1'b0);
    chkb("bp_r0_ready0", q_rdy[0][0], 1'b1);
    for (int i = 1; i <= 6; i++) begin
      tick();
      set_op(0, 32'(100 + i), 32'd1, 4'b0000);
      settle();
      chkb("bp_r1_ready_held", q_rdy[0][1], 1'b0);
      chk("bp_r1_result_hold", q_res[0][1], 32'hFFFFFFFF);
      chkb("bp_r1_valid_hold", q_vld[0][1], 1'b1);
      chkb("bp_r0_ready", q_rdy[0][0], (i % 2 == 0));
    end
    tick();
    v = 2'b10;
    rr = 2'b11;
    settle();
    chkb("bp_r1_release_ready", q_rdy[0][1], 1'b1);
    tick();
    v = 2'b00;
    settle();
    chkb("bp_r1_drained", q_vld[0][1], 1'b0);
    chkb("bp_r0_done", q_vld[0][0], 1'b1);
    tick();
    settle();
    chkb("bp_r1_new_valid", q_vld[0][1], 1'b1);
    chk("bp_r1_new_result", q_res[0][1], 32'd7);
    tick();

    // ---- drain and re-issue in the same cycle on port 0 ----
    do_reset();
    rr = 2'b11;
    v = 2'b01;
    set_op(0, 32'd10, 32'd20, 4'b0000);
    tick();
    set_op(0, 32'd1, 32'd1, 4'b0000);
    tick();
    settle();
    chkb("dr_rsp1_valid", q_vld[0][0], 1'b1);
    chk("dr_rsp1_result", q_res[0][0], 32'd30);
    chkb("dr_reissue_ready", q_rdy[0][0], 1'b1);
    tick();
    v = 2'b00;
    settle();
    chkb("dr_no_duplicate", q_vld[0][0], 1'b0);
    tick();
    settle();
    chkb("dr_rsp2_valid", q_vld[0][0], 1'b1);
    chk("dr_rsp2_result", q_res[0][0], 32'd2);
    tick();
    settle();
    chkb("dr_rsp2_drained", q_vld[0][0], 1'b0);

    // ---- reset in the middle of an operation ----
    do_reset();
    rr = 2'b01;
    v = 2'b10;
    set_op(1, 32'd5, 32'd5, 4'b0000);
    tick();
    v = 2'b01;
    set_op(0, 32'd9, 32'd9, 4'b0000);
    tick();
    v = 2'b00;
    chkb("rm_r1_valid_before", q_vld[0][1], 1'b1);
    chk("rm_alu_a_before", q_alu_a[0], 32'd9);
    #1 rst_n = 1'b0;
    #1;
    chk2("rm_rsp_valid_cleared", q_vld[0], 2'b00);
    chk("rm_alu_a_cleared", q_alu_a[0], 32'h0);
    tick();
    rst_n = 1'b1;
    rr = 2'b11;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk2("rm_no_late_rsp", q_vld[0], 2'b00);
      tick();
    end
    v = 2'b11;
    settle();
    chk2("rm_first_tie_r0", q_rdy[0], 2'b01);
    chk2("rm_first_tie_r0_fp", q_rdy[1], 2'b01);
    tick();

    // ---- random traffic against a transaction-level model ----
    do_reset();
    for (int d = 0; d < 2; d++) begin
      m_last[d] = 1'b1;
      for (int p = 0; p < 2; p++) begin
        m_pend[d][p] = 1'b0;
        m_vis[d][p] = 1'b0;
        m_res[d][p] = '0;
      end
    end
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int p = 0; p < 2; p++) begin
        v[p]  = ($urandom_range(0, 9) < 7);
        rr[p] = ($urandom_range(0, 9) < 6);
        a[p]  = $urandom;
        b[p]  = ($urandom_range(0, 3) == 0) ? a[p] : $urandom;
        c[p]  = codes[$urandom_range(0, 9)];
      end
      settle();
      for (int d = 0; d < 2; d++) begin
        for (int p = 0; p < 2; p++) begin
          bz[p] = m_pend[d][p] && !(m_vis[d][p] && rr[p]);
          el[p] = v[p] && !bz[p];
        end
        if (el == 2'b11) eg = (d == 1 || m_last[d]) ? 2'b01 : 2'b10;
        else             eg = el;
        chk2("rand_grant", q_rdy[d], eg);
        for (int p = 0; p < 2; p++) begin
          chkb("rand_rsp_valid", q_vld[d][p], m_vis[d][p]);
          if (m_vis[d][p]) begin
            chk("rand_rsp_result", q_res[d][p], m_res[d][p]);
            chkb("rand_rsp_zero", q_zero[d][p], m_res[d][p] == 32'h0);
          end
        end
        for (int p = 0; p < 2; p++) begin
          if (m_pend[d][p] && !m_vis[d][p]) m_vis[d][p] = 1'b1;
          else if (m_vis[d][p] && rr[p]) begin
            m_vis[d][p] = 1'b0;
            m_pend[d][p] = 1'b0;
          end
          if (eg[p]) begin
            m_pend[d][p] = 1'b1;
            m_vis[d][p] = 1'b0;
            m_res[d][p] = alu_f(a[p], b[p], c[p]);
            m_last[d] = (p == 1);
          end
        end
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
